wb_stat_poller: RTL and testbench

- Wishbone initiator that periodically reads a set of peripheral registers (e.g. E1 RX tick captures and time counter) and forwards each word on a valid/ready stream toward the USB status endpoint.
- A single-cycle trigger (typically the USB SOF tick) starts one poll sequence over a compile-time address mask.
- Sits between the status-capture peripheral's bus port and the USB data path. It is the master end of the single-outstanding, ack-terminated bus used by the misc peripheral.

---
 rtl/wb_stat_poller_if.sv | 30 +++
 rtl/wb_stat_poller.sv | 161 ++++++++++++++++
 tb/tb_wb_stat_poller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stat_poller_if.sv
// wb_stat_poller_if: Wishbone read port and status word stream between the poller and its neighbours
// Signals:
//   wb_addr   8   word address {4'h0, index}        wb_rdata  32  read data, valid with wb_ack
//   wb_we     1   write enable (always 0)            wb_cyc    1   bus cycle request
//   wb_ack    1   bus acknowledge                    out_data  32  captured word
//   out_addr  4   index the word came from           out_last  1   last word of a sequence
//   out_err   1   word is a timeout filler           out_valid 1   stream valid
//   out_ready 1   stream ready
// Modports: master = poller side, slave = peripheral / stream sink side.
interface wb_stat_poller_if;
    logic [7:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    modport master (
        output wb_addr, wb_we, wb_cyc, out_data, out_addr, out_last, out_err, out_valid,
        input  wb_rdata, wb_ack, out_ready
    );
    modport slave (
        input  wb_addr, wb_we, wb_cyc, out_data, out_addr, out_last, out_err, out_valid,
        output wb_rdata, wb_ack, out_ready
    );
endinterface

// File: rtl/wb_stat_poller.sv
// wb_stat_poller: on each trigger, reads every word address set in ADDR_MASK over Wishbone and streams the words out
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   trig     single-cycle poll request
//   busy     a sequence is in progress
//   ovr_cnt  saturating count of dropped triggers
//   bus      wb_stat_poller_if.master: Wishbone read port plus valid/ready word stream
// Optional feature macro POLLER_TIMEOUT_EN: abort a read after TIMEOUT cycles without ack and emit a
// 32'hFFFFFFFF word with out_err=1 in its place. Without it a read waits for ack indefinitely.
module wb_stat_poller #(
    parameter logic [15:0] ADDR_MASK = 16'h00B0
`ifdef POLLER_TIMEOUT_EN
    ,
    parameter logic [7:0]  TIMEOUT   = 8'd32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig,
    output logic                    busy,
    output logic [7:0]              ovr_cnt,
    wb_stat_poller_if.master        bus
);
    typedef enum logic [1:0] {IDLE, SCAN, REQ, OUT} state_t;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [7:0]  ovr_q, ovr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  oaddr_q, oaddr_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic [15:0] above;
`ifdef POLLER_TIMEOUT_EN
    logic        err_q, err_d;
    logic [7:0]  tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 8'd0;
            data_q  <= 32'd0;
            oaddr_q <= 4'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef POLLER_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            last_q  <= last_d;
            valid_q <= valid_d;
`ifdef POLLER_TIMEOUT_EN
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // 5-bit shift amount so index 15 shifts the whole mask out
    assign above = ADDR_MASK >> ({1'b0, idx_q} + 5'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef POLLER_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        // one request may queue behind the running sequence; further ones are counted as dropped
        if (state_q != IDLE && trig) begin
            if (!pend_q)
                pend_d = 1'b1;
            else if (ovr_q != 8'hFF)
                ovr_d = ovr_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (ADDR_MASK != 16'h0000 && (trig || pend_q)) begin
                    idx_d   = 4'd0;
                    pend_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ADDR_MASK[idx_q]) begin
                    state_d = REQ;
`ifdef POLLER_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            REQ: begin
                if (bus.wb_ack) begin
                    data_d  = bus.wb_rdata;
                    oaddr_d = idx_q;
                    last_d  = (above == 16'h0000);
                    valid_d = 1'b1;
                    state_d = OUT;
`ifdef POLLER_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmo_q == TIMEOUT - 8'd1) begin
                    data_d  = 32'hFFFF_FFFF;
                    oaddr_d = idx_q;
                    last_d  = (above == 16'h0000);
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
`endif
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SCAN;
                    end
                end
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign ovr_cnt       = ovr_q;
    assign bus.wb_addr   = {4'h0, idx_q};
    assign bus.wb_we     = 1'b0;
    // driven straight from the state register so an async reset drops the bus request at once
    assign bus.wb_cyc    = (state_q == REQ);
    assign bus.out_data  = data_q;
    assign bus.out_addr  = oaddr_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;
`ifdef POLLER_TIMEOUT_EN
    assign bus.out_err   = err_q;
`else
    assign bus.out_err   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stat_poller.sv
// tb_wb_stat_poller: directed, table-driven bench for wb_stat_poller (default mask, empty mask, mask 16'h8000)
module tb_wb_stat_poller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig0 = 1'b0, trig1 = 1'b0, trig2 = 1'b0;
    logic       busy0, busy1, busy2;
    logic [7:0] ovr0, ovr1, ovr2;
    logic       ack0, ack2, nack_en;
    int tests = 0, fails = 0, words = 0, run = 0, last_run = 0;
    int bad_run = 0, inv_bad = 0, stab_bad = 0, bad1 = 0;

    typedef struct {
        logic        trig;
        int          stall;
        logic [3:0]  a;
        logic [31:0] d;
        logic        l;
    } vec_t;
    vec_t v[6];

    wb_stat_poller_if bus0();
    wb_stat_poller_if bus1();
    wb_stat_poller_if bus2();

    wb_stat_poller u0 (.clk(clk), .rst(rst), .trig(trig0), .busy(busy0), .ovr_cnt(ovr0), .bus(bus0));
    wb_stat_poller #(.ADDR_MASK(16'h0000)) u1 (.clk(clk), .rst(rst), .trig(trig1), .busy(busy1), .ovr_cnt(ovr1), .bus(bus1));
    wb_stat_poller #(.ADDR_MASK(16'h8000)) u2 (.clk(clk), .rst(rst), .trig(trig2), .busy(busy2), .ovr_cnt(ovr2), .bus(bus2));

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) ack0 <= 1'b0;
        else     ack0 <= bus0.wb_cyc && !ack0 && !(nack_en && bus0.wb_addr == 8'd5);
    assign bus0.wb_ack   = ack0;
    assign bus0.wb_rdata = (bus0.wb_addr == 8'd4) ? 32'h1111_0000 :
                           (bus0.wb_addr == 8'd5) ? 32'h2222_0000 :
                           (bus0.wb_addr == 8'd7) ? 32'h0000_1234 : 32'hDEAD_BEEF;

    assign bus1.wb_ack   = 1'b0;
    assign bus1.wb_rdata = 32'd0;

    always @(posedge clk or posedge rst)
        if (rst) ack2 <= 1'b0;
        else     ack2 <= bus2.wb_cyc && !ack2;
    assign bus2.wb_ack   = ack2;
    assign bus2.wb_rdata = (bus2.wb_addr == 8'd15) ? 32'hCAFE_000F : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (bus0.out_valid && bus0.out_ready) words <= words + 1;
        if (bus0.wb_cyc) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            if (!nack_en && run != 2) bad_run <= bad_run + 1;
            run <= 0;
        end
        if (bus0.wb_we || (bus0.wb_cyc && bus0.out_valid)) inv_bad <= inv_bad + 1;
        if (bus1.wb_cyc || busy1 || bus1.out_valid || bus1.wb_we) bad1 <= bad1 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse0();
        trig0 = 1'b1;
        @(negedge clk);
        trig0 = 1'b0;
    endtask

    task automatic get_word(input int stall, input logic [3:0] a, input logic [31:0] d,
                            input logic l, input logic e, input int id);
        int n = 0;
        logic [31:0] sd;
        logic [3:0]  sa;
        logic        sl;
        bus0.out_ready = 1'b0;
        while (!bus0.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("w%0d_valid", id), {31'd0, bus0.out_valid}, 32'd1);
        repeat (stall) begin
            sd = bus0.out_data;
            sa = bus0.out_addr;
            sl = bus0.out_last;
            @(negedge clk);
            if (!bus0.out_valid || bus0.out_data !== sd || bus0.out_addr !== sa ||
                bus0.out_last !== sl || bus0.wb_cyc) stab_bad++;
        end
        chk($sformatf("w%0d_addr", id), {28'd0, bus0.out_addr}, {28'd0, a});
        chk($sformatf("w%0d_data", id), bus0.out_data, d);
        chk($sformatf("w%0d_last", id), {31'd0, bus0.out_last}, {31'd0, l});
        chk($sformatf("w%0d_err", id), {31'd0, bus0.out_err}, {31'd0, e});
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int w0;
        v[0] = '{1'b1, 0,  4'd4, 32'h1111_0000, 1'b0};
        v[1] = '{1'b0, 0,  4'd5, 32'h2222_0000, 1'b0};
        v[2] = '{1'b0, 0,  4'd7, 32'h0000_1234, 1'b1};
        v[3] = '{1'b1, 10, 4'd4, 32'h1111_0000, 1'b0};
        v[4] = '{1'b0, 0,  4'd5, 32'h2222_0000, 1'b0};
        v[5] = '{1'b0, 0,  4'd7, 32'h0000_1234, 1'b1};
        nack_en = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ovr", {24'd0, ovr0}, 32'd0);
        chk("rst_cyc", {31'd0, bus0.wb_cyc}, 32'd0);
        chk("rst_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_waddr", {24'd0, bus0.wb_addr}, 32'd0);

        // two sequences: free-flowing, then first word back-pressured for 10 cycles
        w0 = words;
        for (int i = 0; i < 6; i++) begin
            if (v[i].trig) pulse0();
            get_word(v[i].stall, v[i].a, v[i].d, v[i].l, 1'b0, i);
            if (v[i].l) chk($sformatf("busy_end%0d", i), {31'd0, busy0}, 32'd0);
        end
        repeat (10) @(negedge clk);
        chk("seq_words", words - w0, 6);

        // start + queued + dropped trigger, then the queued sequence runs
        w0 = words;
        pulse0();
        repeat (2) @(negedge clk);
        pulse0();
        repeat (2) @(negedge clk);
        pulse0();
        chk("ovr_one", {24'd0, ovr0}, 32'd1);
        for (int i = 0; i < 6; i++) get_word(0, v[i % 3].a, v[i % 3].d, v[i % 3].l, 1'b0, 10 + i);
        chk("pend_busy_end", {31'd0, busy0}, 32'd0);
        repeat (10) @(negedge clk);
        chk("pend_words", words - w0, 6);
        chk("pend_idle", {31'd0, busy0}, 32'd0);

        // saturation while stalled on the first word
        pulse0();
        repeat (300) begin
            pulse0();
            @(negedge clk);
        end
        chk("ovr_sat", {24'd0, ovr0}, 32'hFF);
        for (int i = 0; i < 6; i++) get_word(0, v[i % 3].a, v[i % 3].d, v[i % 3].l, 1'b0, 20 + i);
        chk("sat_busy_end", {31'd0, busy0}, 32'd0);

        // empty mask: trigger is ignored
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("mask0_ovr", {24'd0, ovr1}, 32'd0);

        // mask 16'h8000: single word at index 15, marked last
        trig2 = 1'b1;
        @(negedge clk);
        trig2 = 1'b0;
        n = 0;
        while (!bus2.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("m15_valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("m15_addr", {28'd0, bus2.out_addr}, 32'd15);
        chk("m15_data", bus2.out_data, 32'hCAFE_000F);
        chk("m15_last", {31'd0, bus2.out_last}, 32'd1);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("m15_busy", {31'd0, busy2}, 32'd0);
        chk("m15_vlow", {31'd0, bus2.out_valid}, 32'd0);

        // asynchronous reset while a read is outstanding
        pulse0();
        n = 0;
        while (!bus0.wb_cyc && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_cyc_seen", {31'd0, bus0.wb_cyc}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cyc", {31'd0, bus0.wb_cyc}, 32'd0);
        chk("ar_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy0}, 32'd0);
        chk("ar_ovr", {24'd0, ovr0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w0 = words;
        for (int i = 0; i < 3; i++) begin
            if (v[i].trig) pulse0();
            get_word(0, v[i].a, v[i].d, v[i].l, 1'b0, 30 + i);
        end
        repeat (5) @(negedge clk);
        chk("ar_words", words - w0, 3);
        chk("ar_busy_end", {31'd0, busy0}, 32'd0);

`ifdef POLLER_TIMEOUT_EN
        // slave never acks index 5: filler word, then the sequence carries on
        nack_en = 1'b1;
        pulse0();
        get_word(0, 4'd4, 32'h1111_0000, 1'b0, 1'b0, 40);
        get_word(0, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 41);
        chk("tmo_cyc_len", last_run, 32);
        get_word(0, 4'd7, 32'h0000_1234, 1'b1, 1'b0, 42);
        nack_en = 1'b0;
        repeat (3) @(negedge clk);
`endif

        chk("cyc_run_len", bad_run, 0);
        chk("we_and_backpressure", inv_bad, 0);
        chk("stall_stable", stab_bad, 0);
        chk("mask0_quiet", bad1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
